// File: rtl/sprite_drawer_pkg.sv
// Shared constants for the sprite drawer: screen geometry, FSM state codes,
// source-select codes and the background address helper.
package sprite_drawer_pkg;

  localparam int SCREEN_W  = 320;
  localparam int SCREEN_H  = 240;
  localparam int BG_ADDR_W = 17;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LATCH   = 3'd1;
  localparam logic [2:0] ST_SCAN    = 3'd2;
  localparam logic [2:0] ST_FLUSH   = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;
  localparam logic [2:0] ST_RELEASE = 3'd5;

  localparam logic SRC_BG   = 1'b0;
  localparam logic SRC_CHAR = 1'b1;

  // y*320 + x without a multiplier: (y<<8) + (y<<6) + x.
  function automatic logic [BG_ADDR_W-1:0] bg_addr(input logic [8:0] x, input logic [7:0] y);
    return {1'b0, y, 8'h00} + {3'b000, y, 6'h00} + {8'h00, x};
  endfunction

endpackage

// File: rtl/sprite_scan_counter.sv
// Column/row raster counter over a SPRITE_W x SPRITE_H window with a
// last-pixel flag; clear has priority over enable.
module sprite_scan_counter #(
  parameter int SPRITE_W = 8,
  parameter int SPRITE_H = 8,
  parameter int COL_W    = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1,
  parameter int ROW_W    = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             clear,
  input  logic             enable,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             last
);

  localparam logic [COL_W-1:0] COL_MAX = COL_W'(SPRITE_W - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(SPRITE_H - 1);

  always_ff @(posedge clock) begin
    if (!resetn || clear) begin
      col <= '0;
      row <= '0;
    end else if (enable) begin
      if (col == COL_MAX) begin
        col <= '0;
        row <= (row == ROW_MAX) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign last = (col == COL_MAX) && (row == ROW_MAX);

endmodule

// File: rtl/sprite_drawer.sv
// Raster-scans a sprite window, reads colour from the char or background ROM
// and emits clipped plot strobes, then pulses the matching done signal.
module sprite_drawer
  import sprite_drawer_pkg::*;
#(
  parameter int                  SPRITE_W    = 8,
  parameter int                  SPRITE_H    = 8,
  parameter int                  COLOUR_W    = 9,
  parameter logic [COLOUR_W-1:0] TRANSPARENT = {COLOUR_W{1'b1}},
  parameter int                  CHAR_AW     = $clog2(SPRITE_W * SPRITE_H)
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 drawBG,
  input  logic                 drawChar,
  input  logic [8:0]           xIn,
  input  logic [7:0]           yIn,
  output logic [CHAR_AW-1:0]   charAddr,
  input  logic [COLOUR_W-1:0]  charData,
  output logic [BG_ADDR_W-1:0] bgAddr,
  input  logic [COLOUR_W-1:0]  bgData,
  output logic [8:0]           vgaX,
  output logic [7:0]           vgaY,
  output logic [COLOUR_W-1:0]  colour,
  output logic                 plot,
  output logic                 doneBG,
  output logic                 doneChar,
  output logic                 busy
);

  localparam int COL_W = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int ROW_W = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

  logic [2:0]       state;
  logic [2:0]       state_next;
  logic             src;
  logic [8:0]       x0;
  logic [7:0]       y0;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             last;
  logic             cnt_clear;
  logic             cnt_en;
  logic             scan_valid;
  logic             valid_q;
  logic             on_q;
  logic             request;
  logic [9:0]       px_full;
  logic [8:0]       py_full;
  logic             onscreen;
  logic             transparent;

  assign request = drawBG || drawChar;

  sprite_scan_counter #(
    .SPRITE_W (SPRITE_W),
    .SPRITE_H (SPRITE_H),
    .COL_W    (COL_W),
    .ROW_W    (ROW_W)
  ) u_scan (
    .clock  (clock),
    .resetn (resetn),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .col    (col),
    .row    (row),
    .last   (last)
  );

  // State register
  always_ff @(posedge clock) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (request) state_next = ST_LATCH;
      ST_LATCH:   state_next = ST_SCAN;
      ST_SCAN:    if (last) state_next = ST_FLUSH;
      ST_FLUSH:   state_next = ST_DONE;
      ST_DONE:    state_next = ST_RELEASE;
      ST_RELEASE: if (!request) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    busy       = 1'b0;
    doneBG     = 1'b0;
    doneChar   = 1'b0;
    cnt_clear  = 1'b0;
    cnt_en     = 1'b0;
    scan_valid = 1'b0;
    case (state)
      ST_IDLE:  busy = 1'b0;
      ST_LATCH: begin
        busy      = 1'b1;
        cnt_clear = 1'b1;
      end
      ST_SCAN: begin
        busy       = 1'b1;
        cnt_en     = 1'b1;
        scan_valid = 1'b1;
      end
      ST_DONE: begin
        busy     = 1'b1;
        doneBG   = (src == SRC_BG);
        doneChar = (src == SRC_CHAR);
      end
      default: busy = 1'b1;
    endcase
  end

  // Source is chosen at the IDLE decision; coordinates are frozen in LATCH.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      src <= SRC_BG;
      x0  <= '0;
      y0  <= '0;
    end else begin
      if (state == ST_IDLE && request) src <= drawBG ? SRC_BG : SRC_CHAR;
      if (state == ST_LATCH) begin
        x0 <= xIn;
        y0 <= yIn;
      end
    end
  end

  // Extra top bit keeps X/Y carry-out visible so clipped pixels never wrap.
  assign px_full  = {1'b0, x0} + 10'(col);
  assign py_full  = {1'b0, y0} + 9'(row);
  assign onscreen = (px_full < 10'(SCREEN_W)) && (py_full < 9'(SCREEN_H));

  assign charAddr = CHAR_AW'(row) * CHAR_AW'(SPRITE_W) + CHAR_AW'(col);
  assign bgAddr   = bg_addr(px_full[8:0], py_full[7:0]);

  // Coordinates travel one stage to line up with the ROM's read latency.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      on_q    <= 1'b0;
      vgaX    <= '0;
      vgaY    <= '0;
    end else begin
      valid_q <= scan_valid;
      on_q    <= onscreen;
      if (scan_valid) begin
        vgaX <= px_full[8:0];
        vgaY <= py_full[7:0];
      end
    end
  end

  assign transparent = (src == SRC_CHAR) && (charData == TRANSPARENT);
  assign colour      = valid_q ? ((src == SRC_CHAR) ? charData : bgData) : '0;
  assign plot        = valid_q && on_q && !transparent;

endmodule
